// File: rtl/cla_share_arbiter_if.sv
// Requester, shared-adder and response signals of the CLA share arbiter.
// The slave modport is the arbiter. The master modport is the requester/adder/consumer side.
interface cla_share_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        req_sub;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       add_a;
    logic [DATA_W-1:0]       add_b;
    logic                    add_cin;
    logic [DATA_W-1:0]       add_s;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_ready;
    logic                    busy;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, add_s, rsp_ready,
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, add_s, rsp_ready,
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/cla_share_arbiter.sv
// Round-robin scheduler that time-shares one external carry-lookahead adder
// between N_REQ requesters and returns each sum on a tagged response channel.
//
// state | meaning
// IDLE  | searching from ptr for a valid requester, grant asserted combinationally
// EXEC  | latched operands on the adder ports, sum captured at the closing edge
// RESP  | rsp_valid high, data/id held until rsp_ready
module cla_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    cla_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic                accept;
    logic [DATA_W-1:0]   op_a_q;
    logic [DATA_W-1:0]   op_b_q;
    logic                op_cin_q;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [ID_W-1:0]     rsp_id_q;

    // Walk downward so the last hit, the one closest above ptr, wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr_q) + k) % N_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    // rst_n gating keeps the grant low while the block is held in reset.
    assign accept = rst_n && (state_q == IDLE) && grant_found;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_ready[i] = accept && (grant_id == ID_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q   <= bus.req_a[grant_id*DATA_W +: DATA_W];
                // Subtraction as A + ~B + 1 through the same adder.
                op_b_q   <= bus.req_sub[grant_id] ? ~bus.req_b[grant_id*DATA_W +: DATA_W]
                                                  :  bus.req_b[grant_id*DATA_W +: DATA_W];
                op_cin_q <= bus.req_sub[grant_id];
                id_q     <= grant_id;
                ptr_q    <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= bus.add_s;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign bus.add_a     = op_a_q;
    assign bus.add_b     = op_b_q;
    assign bus.add_cin   = op_cin_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/cla_share_arbiter.md
# cla_share_arbiter

Round-robin scheduler sharing one 16-bit carry-lookahead adder between up to N_REQ requesters (autoencoder neuron/accumulator lanes). Accepts one add or subtract request at a time through per-requester valid/ready handshakes. Registers operands, drives the shared adder's operand and carry-in ports, and captures the sum. Returns the sum on a common response channel tagged with the requester index and holds it under backpressure.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- DATA_W, default 16: operand/result width; must match the shared adder.
- ID_W, default 2: requester index width, $clog2(N_REQ).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  request pending, one bit per requester.
- req_a  in  N_REQ*DATA_W  operand A; requester i uses bits [i*DATA_W +: DATA_W].
- req_b  in  N_REQ*DATA_W  operand B; same packing as req_a.
- req_sub  in  N_REQ  1 = A - B, 0 = A + B.
- req_ready  out  N_REQ  one-hot grant/accept.
- add_a  out  DATA_W  to the shared adder's operand 1.
- add_b  out  DATA_W  to the shared adder's operand 2.
- add_cin  out  1  to the shared adder's carry-in.
- add_s  in  DATA_W  from the shared adder's result.
- rsp_valid  out  1  result available.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  DATA_W  captured add_s.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in EXEC or RESP.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant goes to the first requester with req_valid=1, searching upward (with wrap) from the round-robin pointer `ptr`.
  - req_ready is asserted combinationally for the granted index only, and only in IDLE.
  - On accept (req_valid[g] & req_ready[g]):
    - latch opA = req_a[g];
    - latch opB = req_sub[g] ? ~req_b[g] : req_b[g];
    - latch cin = req_sub[g];
    - latch id = g;
    - set ptr <= (g+1) mod N_REQ;
    - go to EXEC.
  - If no request is valid, stay in IDLE; ptr is unchanged.
- **EXEC** (exactly one cycle)
  - add_a/add_b/add_cin are driven from the latched registers; the adder's combinational path settles in this cycle.
  - At the clock edge: rsp_data <= add_s, rsp_id <= id; go to RESP.
- **RESP**
  - rsp_valid=1; rsp_data and rsp_id are held stable until rsp_ready=1.
  - On rsp_ready=1: go to IDLE.
  - A new request cannot be accepted in the same cycle as rsp_ready; the earliest accept is the next cycle.
- add_a/add_b/add_cin are register outputs and hold their last values outside EXEC. The adder may be probed, but its output is only sampled in EXEC.
- The arbiter applies no arithmetic interpretation. Sum width is DATA_W, wraps mod 2^DATA_W, and rsp_data is exactly the adder output. Overflow and sign handling belong to the adder and its consumer.
- A requester deasserting req_valid while not granted is legal and causes no effect. Operands must stay stable while req_valid=1; the block samples them only at accept.
- Reset at any point returns the block to IDLE and clears every register, whether or not a request is in flight or a response is pending. The aborted request is dropped without a response.

## Timing
- Reset values: req_ready=0 (registered state IDLE, but no grant until rst_n is deasserted), add_a=0, add_b=0, add_cin=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, ptr=0.
- Latency: accept at edge t → EXEC in cycle t+1 → rsp_valid=1 from cycle t+2.
- With rsp_ready tied high, throughput is one request per 3 cycles.
- req_ready is a combinational function of the state, ptr and req_valid. It has no combinational path from req_a, req_b or rsp_ready.
- rsp_valid and busy are decoded from registered state.
- The adder's combinational path must close within one clk period: add_a → add_s → rsp_data register.

## Test plan
- Single add: req0, A=0x0003, B=0x0004, sub=0, rsp_ready=1.
  - Required: req_ready[0] is high in the accept cycle; rsp_valid rises 2 cycles later with rsp_id=0, rsp_data=0x0007; busy is high for 2 cycles.
- Subtract: req2, A=0x0010, B=0x0001, sub=1.
  - Required: in EXEC, add_b=0xFFFE and add_cin=1; rsp_data=0x000F, rsp_id=2.
- Round robin: all 4 req_valid held high continuously, rsp_ready=1.
  - Required: grant order 0,1,2,3,0; each grant is spaced 3 cycles apart; no requester is granted twice before the others are served.
- Backpressure: req1 A=0x1234, B=0x1111; rsp_ready=0 for 5 cycles, then 1.
  - Required: rsp_data=0x2345, rsp_id=1 are held stable while stalled; req_ready stays all-zero throughout.
  - Required: after rsp_ready=1, the next accept occurs one cycle later.
- Reset mid-operation: assert rst_n=0 during EXEC, and again during RESP with rsp_ready=0.
  - Required: all outputs are 0 immediately; after release, no response appears for the dropped request; ptr=0, so a fresh req3 alone is granted correctly.
- Wrap: req0, A=0xFFFF, B=0x0001, sub=0.
  - Required: rsp_data equals the adder's output for these operands, checked against the golden adder model; the arbiter leaves the value unaltered.
